// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch over a handshaked imem bus,
// in-order prefetch queue toward decode, and redirect with drop counting of stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  logic [AW-1:0] q_head;
  logic [AW-1:0] q_tail;
  logic [31:0]   tag_mem [DEPTH];
  logic [31:0]   q_data  [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [CW:0]   in_use;
  logic          req_fire;
  logic          resp_take;
  logic          q_push;
  logic          q_pop;
  logic          unused_pc_bits;

  // Every in-flight request owns a queue slot, so the queue can never overflow.
  assign in_use         = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = rst_n && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign resp_take      = imem_resp_valid && (outstanding != '0);
  assign q_push         = resp_take && !redirect && (drop_cnt == '0);
  assign q_pop          = instr_valid && instr_ready && !redirect;

  assign instr_valid    = (q_count != '0);
  assign instr          = q_data[q_head];
  assign instr_pc       = q_pc[q_head];
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (redirect)
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;

      outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);

      if (redirect)
        drop_cnt <= outstanding - CW'(resp_take);
      else if (resp_take && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);

      if (req_fire)
        tag_wr <= tag_wr + AW'(1);
      if (resp_take)
        tag_rd <= tag_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      tag_mem[tag_wr] <= fetch_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      q_head  <= q_tail;
      q_count <= '0;
    end else begin
      if (q_push) begin
        q_data[q_tail] <= imem_resp_data;
        q_pc[q_tail]   <= tag_mem[tag_rd];
        q_tail         <= q_tail + AW'(1);
      end
      if (q_pop)
        q_head <= q_head + AW'(1);
      q_count <= q_count + CW'(q_push) - CW'(q_pop);
    end
  end

  resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (outstanding != '0));
  credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    in_use <= (CW+1)'(DEPTH));
  drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order 1-cycle-latency memory model plus
// scenario tasks with hand-derived cycle expectations (DEPTH = 2, RESET_PC = 0).
module tb_fetch_unit;
  localparam logic [31:0] KEY = 32'h1300_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        mem_hold;
  logic [31:0] pend[$];
  logic [31:0] acc_log[$];
  int          checks;
  int          passes;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ KEY;
  endfunction

  // Memory: log accepted requests at the edge, answer one per cycle starting the next cycle.
  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      pend.push_back(imem_req_addr);
      acc_log.push_back(imem_req_addr);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else if (!mem_hold && pend.size() > 0) begin
      imem_resp_data  = inst_of(pend.pop_front());
      imem_resp_valid = 1'b1;
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  task automatic apply_reset;
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    acc_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); else passes++;
    checks++; if (imem_req_addr !== 32'h0) $display("[TB] FAIL reset_req_addr: got %h expected 00000000", imem_req_addr); else passes++;
    checks++; if (instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h expected 00000000", instr); else passes++;
    checks++; if (instr_pc !== 32'h0) $display("[TB] FAIL reset_instr_pc: got %h expected 00000000", instr_pc); else passes++;
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    apply_reset();
    instr_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("[TB] FAIL stream_req0: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else passes++;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("[TB] FAIL stream_req1: got v=%b a=%h expected v=1 a=00000004", imem_req_valid, imem_req_addr); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL stream_not_yet: got %b expected 0", instr_valid); else passes++;
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== inst_of(32'h0)) $display("[TB] FAIL stream_first: got v=%b pc=%h i=%h expected v=1 pc=00000000 i=%h", instr_valid, instr_pc, instr, inst_of(32'h0)); else passes++;
    exp = 32'h4;
    for (int c = 0; c < 10 && exp != 32'hC; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        checks++; if (instr_pc !== exp || instr !== inst_of(exp)) $display("[TB] FAIL stream_order: got pc=%h i=%h expected pc=%h i=%h", instr_pc, instr, exp, inst_of(exp)); else passes++;
        exp += 32'h4;
      end
    end
    checks++; if (exp !== 32'hC) $display("[TB] FAIL stream_timeout: got next pc %h expected 0000000c", exp); else passes++;
  endtask

  task automatic test_consumer_stall;
    logic [31:0] exp;
    apply_reset();
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL stall_req_valid: got %b expected 0", imem_req_valid); else passes++;
    checks++; if (acc_log.size() != 2) $display("[TB] FAIL stall_accepts: got %0d expected 2", acc_log.size()); else passes++;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("[TB] FAIL stall_head: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); else passes++;
    @(negedge clk);
    instr_ready = 1'b1;
    exp = 32'h0;
    for (int c = 0; c < 15 && exp != 32'h10; c++) begin
      #1;
      if (instr_valid) begin
        checks++; if (instr_pc !== exp || instr !== inst_of(exp)) $display("[TB] FAIL stall_order: got pc=%h i=%h expected pc=%h i=%h", instr_pc, instr, exp, inst_of(exp)); else passes++;
        exp += 32'h4;
      end
      @(negedge clk);
    end
    checks++; if (exp !== 32'h10) $display("[TB] FAIL stall_timeout: got next pc %h expected 00000010", exp); else passes++;
    checks++; if (acc_log.size() < 3 || acc_log[2] !== 32'h8) $display("[TB] FAIL stall_resume_addr: got n=%0d expected third request 00000008", acc_log.size()); else passes++;
  endtask

  task automatic test_req_stall;
    apply_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("[TB] FAIL hold_addr: got v=%b a=%h expected v=1 a=00000004", imem_req_valid, imem_req_addr); else passes++;
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) $display("[TB] FAIL hold_accept: got v=%b a=%h expected v=1 a=00000004", imem_req_valid, imem_req_addr); else passes++;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) $display("[TB] FAIL hold_next: got v=%b a=%h expected v=1 a=00000008", imem_req_valid, imem_req_addr); else passes++;
  endtask

  task automatic test_redirect;
    int c;
    bit seen;
    apply_reset();
    instr_ready = 1'b1;
    c = 0;
    while (!(acc_log.size() == 2 && pend.size() == 0) && c < 20) begin
      @(negedge clk); #1; c++;
    end
    mem_hold = 1'b1;
    while (acc_log.size() < 4 && c < 40) begin
      @(negedge clk); #1; c++;
    end
    checks++; if (acc_log.size() != 4 || acc_log[2] !== 32'h8 || acc_log[3] !== 32'hC) $display("[TB] FAIL redir_setup: got %0d accepts expected 4 ending 8,c", acc_log.size()); else passes++;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_credit: got %b expected 0", imem_req_valid); else passes++;
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL redir_force: got %b expected 0", imem_req_valid); else passes++;
    mem_hold = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b0) $display("[TB] FAIL redir_addr: got v=%b a=%h expected v=0 a=00000100", imem_req_valid, imem_req_addr); else passes++;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        seen = 1'b1;
        checks++; if (instr_pc !== 32'h100 || instr !== inst_of(32'h100)) $display("[TB] FAIL redir_first: got pc=%h i=%h expected pc=00000100 i=%h", instr_pc, instr, inst_of(32'h100)); else passes++;
      end
    end
    checks++; if (!seen) $display("[TB] FAIL redir_timeout: got no instruction expected pc 00000100"); else passes++;
    checks++; if (acc_log.size() < 5 || acc_log[4] !== 32'h100) $display("[TB] FAIL redir_req: got n=%0d expected fifth request 00000100", acc_log.size()); else passes++;
  endtask

  task automatic test_back_to_back;
    bit seen;
    apply_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("[TB] FAIL b2b_pop_head: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); else passes++;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL b2b_flushed: got %b expected 0", instr_valid); else passes++;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) $display("[TB] FAIL b2b_req: got v=%b a=%h expected v=1 a=00000200", imem_req_valid, imem_req_addr); else passes++;
    @(negedge clk);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      #1;
      if (instr_valid) begin
        seen = 1'b1;
        checks++; if (instr_pc !== 32'h300 || instr !== inst_of(32'h300)) $display("[TB] FAIL b2b_first: got pc=%h i=%h expected pc=00000300 i=%h", instr_pc, instr, inst_of(32'h300)); else passes++;
      end
      @(negedge clk);
    end
    checks++; if (!seen) $display("[TB] FAIL b2b_timeout: got no instruction expected pc 00000300"); else passes++;
    checks++; if (acc_log.size() < 5 || acc_log[4] !== 32'h300) $display("[TB] FAIL b2b_req: got n=%0d expected fifth request 00000300", acc_log.size()); else passes++;
  endtask

  task automatic test_wrap_and_reset;
    apply_reset();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL wrap_force: got %b expected 0", imem_req_valid); else passes++;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_top: got v=%b a=%h expected v=1 a=fffffffc", imem_req_valid, imem_req_addr); else passes++;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("[TB] FAIL wrap_zero: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); else passes++;
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== inst_of(32'hFFFF_FFFC)) $display("[TB] FAIL wrap_instr: got v=%b pc=%h expected v=1 pc=fffffffc", instr_valid, instr_pc); else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL async_instr_valid: got %b expected 0", instr_valid); else passes++;
    checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) $display("[TB] FAIL async_req: got v=%b a=%h expected v=0 a=00000000", imem_req_valid, imem_req_addr); else passes++;
    checks++; if (instr_pc !== 32'h0 || instr !== 32'h0) $display("[TB] FAIL async_outputs: got pc=%h i=%h expected 00000000", instr_pc, instr); else passes++;
    apply_reset();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    passes          = 0;
    mem_hold        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    test_reset();
    test_stream();
    test_consumer_stall();
    test_req_stall();
    test_redirect();
    test_back_to_back();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
